// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports and D_MEM port bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;

    logic          mem_stall;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_memwrite;
    logic          mem_memread;
    logic [DW-1:0] mem_read_data;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_read_data,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output mem_stall, mem_address, mem_write_data, mem_memwrite, mem_memread
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_read_data,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  mem_stall, mem_address, mem_write_data, mem_memwrite, mem_memread
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port D_MEM arbiter/sequencer (IDLE/ISSUE/DONE) with MEM-stage stall
// Optional DMEM_ARB_FIXED_PRI_EN: port 0 always wins ties; default is round-robin.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          sel;
    logic          any_req;
    logic          grant1;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    assign any_req       = bus.p0_req | bus.p1_req;
    assign bus.mem_stall = bus.p0_req & ~bus.p0_ack;

`ifdef DMEM_ARB_FIXED_PRI_EN
    assign grant1 = bus.p1_req & ~bus.p0_req;
`else
    logic last;

    // Port 1 wins a tie only when port 0 was served last.
    assign grant1 = bus.p1_req & (~bus.p0_req | ~last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (state == DONE) begin
            last <= sel;
        end
    end
`endif

    always_comb begin
        win_we    = bus.p0_we;
        win_addr  = bus.p0_addr;
        win_wdata = bus.p0_wdata;
        if (grant1) begin
            win_we    = bus.p1_we;
            win_addr  = bus.p1_addr;
            win_wdata = bus.p1_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel                <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.mem_memwrite   <= 1'b0;
            bus.mem_memread    <= 1'b0;
            bus.p0_ack         <= 1'b0;
            bus.p1_ack         <= 1'b0;
            bus.p0_rdata       <= '0;
            bus.p1_rdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel                <= grant1;
                        bus.mem_address    <= win_addr;
                        bus.mem_write_data <= win_wdata;
                        bus.mem_memwrite   <= win_we;
                        bus.mem_memread    <= ~win_we;
                    end
                end
                ISSUE: begin
                    // Write commits in D_MEM on this edge; read data is valid right now.
                    bus.mem_memwrite <= 1'b0;
                    bus.mem_memread  <= 1'b0;
                    if (sel) begin
                        bus.p1_ack <= 1'b1;
                        if (bus.mem_memread) bus.p1_rdata <= bus.mem_read_data;
                    end else begin
                        bus.p0_ack <= 1'b1;
                        if (bus.mem_memread) bus.p0_rdata <= bus.mem_read_data;
                    end
                end
                DONE: begin
                    bus.p0_ack <= 1'b0;
                    bus.p1_ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the data memory (`D_MEM`). It shares the single `D_MEM` port between the pipeline MEM stage (port 0) and the loader/DMA engine (port 1). Each access runs through a three-state sequence that drives `D_MEM` address, write data and `memwrite`/`memread`, captures read data and acknowledges the requester. It also generates the MEM-stage stall.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `p0_req`  in  1  port 0 (MEM stage) request; held until `p0_ack`
- `p0_we`  in  1  port 0: 1 = write, 0 = read
- `p0_addr`  in  AW  port 0 address
- `p0_wdata`  in  DW  port 0 write data
- `p0_ack`  out  1  port 0 completion, one-cycle pulse
- `p0_rdata`  out  DW  port 0 read data; valid while `p0_ack` is high, held until the next port 0 read
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_rdata`: same as port 0, for port 1
- `mem_stall`  out  1  `p0_req & ~p0_ack`, combinational; stalls IF/ID/EX/MEM
- `mem_address`  out  AW  to `D_MEM.address`
- `mem_write_data`  out  DW  to `D_MEM.write_data`
- `mem_memwrite`  out  1  to `D_MEM.memwrite`
- `mem_memread`  out  1  to `D_MEM.memread`
- `mem_read_data`  in  DW  from `D_MEM.read_data`; combinational from `mem_address` while `mem_memread` = 1

## Operation
- FSM states: IDLE, ISSUE, DONE.
- **IDLE**
  - If any `pi_req` = 1, select a winner.
  - Latch the winner's addr, wdata and we into `mem_address`, `mem_write_data` and the `sel` register.
  - Set `mem_memwrite` = we or `mem_memread` = ~we, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- **ISSUE**
  - Memory controls are held for exactly this one cycle.
  - Writes commit in `D_MEM` at the edge that ends ISSUE.
  - For reads, `mem_read_data` is captured into `p<sel>_rdata` at that same edge.
  - At that edge, clear `mem_memwrite` and `mem_memread`, set `p<sel>_ack` = 1, and go to DONE.
- **DONE**
  - `p<sel>_ack` is high for this cycle only.
  - Update the round-robin pointer: `last` = `sel`.
  - Clear the ack and go to IDLE.
- **Arbitration**
  - Round-robin between the two ports: when both request in IDLE, grant the port ≠ `last`.
  - A single requester is always granted.
  - `last` resets to 1, so port 0 wins the first tie.
- **Requester rules**
  - A requester holds req, we, addr and wdata stable until it samples ack.
  - It deasserts req, or presents a new request, in the cycle after ack.
  - The arbiter samples inputs only in IDLE, so changes outside IDLE are ignored.
- **Boundary conditions**
  - `p<other>_rdata` is not disturbed by an access from the other port.
  - A write leaves `pi_rdata` unchanged.
  - `mem_address` and `mem_write_data` keep their last values in IDLE and DONE. They are don't-care to `D_MEM` because both strobes are low.
- **Reset (asserted at any time, including mid-operation)**
  - All outputs, `sel`, both rdata registers and the FSM clear immediately: FSM = IDLE, `last` = 1, and all mem_* and ack outputs = 0.
  - A write whose ISSUE edge has not yet occurred is not committed.
  - The aborted requester receives no ack. It must re-request after reset deasserts.

## Timing
- Request seen at IDLE edge k:
  - ISSUE runs during cycle k+1.
  - `ack` is high during cycle k+2.
  - FSM is back in IDLE during cycle k+3.
- Latency from the sampling edge to ack is 2 cycles. Throughput is one access per 3 cycles.
- Back-to-back accesses from alternating ports under contention: port 0 and port 1 acks are 3 cycles apart.
- `mem_stall` rises combinationally with `p0_req`. It falls in the cycle `p0_ack` is high, so the pipeline advances on that edge.
- Reset values: `p0_ack` = `p1_ack` = 0, `p0_rdata` = `p1_rdata` = 0, `mem_address` = 0, `mem_write_data` = 0, `mem_memwrite` = `mem_memread` = 0, `mem_stall` = `p0_req`.

## Configuration
- `DMEM_ARB_FIXED_PRI_EN`
  - Defined: fixed priority. Port 0 always wins a tie, and the `last` register is removed. Port 1 may starve while the pipeline issues continuous memory operations; this is accepted for single-step debug builds.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with `p0_req` = 1 → all mem_* outputs, acks and rdata stay 0; `mem_stall` = 1.
- **Port 0 write then read:** write addr 0x0A, data 0x00001100, then read 0x0A.
  - Write: `mem_memwrite` high for exactly 1 cycle with `mem_address` = 0x0A; `p0_ack` high 2 cycles after the request was sampled.
  - Read: `p0_rdata` = 0x00001100 when `p0_ack` is high.
- **Simultaneous requests from reset:**
  - Stimulus: port 0 writes 0x0B ← 0x00001111; port 1 reads 0x0B; both asserted in the same cycle.
  - Required: port 0 granted first; `p1_ack` 3 cycles after `p0_ack`; `p1_rdata` = 0x00001111.
- **Sustained contention:** both ports request continuously for 12 cycles → acks alternate 0,1,0,1, 3 cycles apart. With `DMEM_ARB_FIXED_PRI_EN`, only `p0_ack` pulses.
- **Reset during ISSUE of a write of 0xDEADBEEF to 0x10** → `mem_memwrite` drops immediately, no ack. A subsequent read of 0x10 does not return 0xDEADBEEF.
- **Port isolation:** port 1 reads 0x20 (= 0x5), then port 0 reads 0x24 (= 0x7) → `p1_rdata` stays 0x5 after port 0's access; `p0_rdata` = 0x7.
